ghost_mode_ctrl: RTL
====================

Name: ghost_mode_ctrl

Overview:
- Global ghost behaviour sequencer. Produces the shared game_mode bus consumed by every per-ghost target generator.
- Runs the classic scatter/chase phase schedule on frame ticks and overrides it with frightened mode after a power pellet.
- Issues a one-cycle reverse pulse to the ghost movers on every mode change that requires ghosts to turn around.
- One instance per design; it sits between the game-control logic and the four ghost pipelines.

Parameters:
- TICKS_PER_SEC, 60: tick pulses per second; all durations are seconds × this value. The bench uses 1.
- FRIGHT_SEC, 6: frightened-mode duration, in seconds.
- FLASH_SEC, 2: length of the warning-flash window at the end of frightened mode, in seconds.
- FLASH_PERIOD, 8: ticks per flash half-period.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- tick  in  1  one-cycle pulse per frame; all timing advances only on tick
- level_start  in  1  pulse; restarts the schedule at phase 0
- run  in  1  high = timers advance; low = freeze everything (death, level-end)
- pellet_eaten  in  1  pulse; enter or restart frightened mode
- dev_mode  in  1  debug; freezes timers and holds game_mode at SCATTER
- game_mode  out  2  `CHASE_MODE / `SCATTER_MODE / `FRIGHTENED_MODE (from constants.vh)
- reverse  out  1  one-cycle pulse; ghosts reverse direction
- fright_flash  out  1  ghost sprite flash select
- phase_idx  out  3  current schedule phase 0..7 (debug/HUD)

Behaviour:
- Reset values: state IDLE, phase_idx=0, phase counter=0, fright counter=0, saved_mode=SCATTER, game_mode=`SCATTER_MODE, reverse=0, fright_flash=0.
- FSM states: IDLE, SCATTER, CHASE, FRIGHT.
- IDLE: outputs SCATTER and ignores tick and pellet_eaten. level_start -> SCATTER, phase_idx=0, counters cleared.
- Schedule, durations in seconds: phase0 S7, phase1 C20, phase2 S7, phase3 C20, phase4 S5, phase5 C20, phase6 S5, phase7 C infinite.
  - Even phases are scatter; odd phases are chase.
  - Phase 7 never expires; its counter saturates and never wraps.
- SCATTER/CHASE, on tick && run:
  - Increment the phase counter.
  - When it reaches duration×TICKS_PER_SEC−1: advance phase_idx, clear the counter, switch state, pulse reverse.
- FRIGHT:
  - The phase counter is paused.
  - The fright counter increments on tick && run.
  - At FRIGHT_SEC×TICKS_PER_SEC−1: return to saved_mode's state. No reverse pulse on exit.
- pellet_eaten (any of SCATTER/CHASE/FRIGHT):
  - Clear the fright counter and enter FRIGHT.
  - Pulse reverse only if the previous state was not FRIGHT.
  - saved_mode captures the schedule mode.
- Latency:
  - Registered outputs. game_mode and reverse change on the clock edge after the causing tick or pulse.
  - reverse is high for exactly one clk cycle.
- run=0: tick is ignored. pellet_eaten and level_start are still honoured, and the counters stay frozen.
- dev_mode=1: no counter advances; game_mode is forced to SCATTER; reverse is held 0. Internal state is preserved, so it resumes exactly when dev_mode drops.
- Simultaneous events:
  - Priority: level_start > phase expiry > pellet_eaten.
  - Phase expiry and pellet in the same cycle: phase_idx advances, saved_mode takes the new phase mode, the state becomes FRIGHT, and reverse pulses once.
  - Fright expiry and pellet in the same cycle: the pellet wins and the fright counter restarts.
- level_start mid-fright: abandon fright and restart at phase0 SCATTER; reverse is not pulsed.
- Counter widths: sized with $clog2 of the largest duration in ticks (20×TICKS_PER_SEC, FRIGHT_SEC×TICKS_PER_SEC). No arithmetic overflow is possible.

Optional Feature:
- GHOST_MODE_FLASH_EN defined:
  - In FRIGHT with remaining ticks ≤ FLASH_SEC×TICKS_PER_SEC, fright_flash toggles every FLASH_PERIOD ticks, starting at 1.
  - fright_flash is 0 outside that window and outside FRIGHT.
- Undefined: fright_flash is tied 0 and the flash counter logic is absent.

Decomposition:
- Shared package ghost_pkg:
  - ghost_state_t enum (IDLE/SCATTER/CHASE/FRIGHT).
  - Phase duration constant array PHASE_SEC[0:7], with 0 meaning infinite.
  - NUM_PHASES constant.
- Mode encodings remain the constants.vh macros.
- One natural sub-module: tick_timer, a loadable tick counter with enable, clear and terminal-count pulse. It is instantiated twice, once for the phase counter and once for the fright counter.

Test Plan (TICKS_PER_SEC=1):
- Reset, then level_start, then 7 ticks -> game_mode SCATTER through tick 6; CHASE after tick 7 (phase_idx=1); one reverse pulse.
- Full schedule of 84 ticks -> phase_idx reaches 7 with 7 reverse pulses total. 200 further ticks -> stays CHASE, no pulses.
- At phase1 tick 10, pellet_eaten -> FRIGHT plus reverse. 6 ticks later -> CHASE with no reverse; phase1 expires 10 ticks after that.
- Pellet during FRIGHT at fright tick 4 -> no reverse; FRIGHT lasts 6 more ticks.
- Phase expiry and pellet in the same cycle at phase0 end -> FRIGHT, a single reverse pulse; after 6 ticks -> CHASE, phase_idx=1.
- run=0 for 50 ticks mid-phase, and separately dev_mode=1 -> no counter progress. With dev_mode, game_mode=SCATTER. Resumes with the identical remaining time.
- With GHOST_MODE_FLASH_EN and FLASH_PERIOD=1: fright_flash is 0 for fright ticks 0–3, then toggles 1,0 on ticks 4 and 5.

Source files
------------

// File: rtl/ghost_mode_ctrl_pkg.sv
// Shared types and constants for the ghost mode sequencer.
// Holds the FSM state type, the scatter/chase phase schedule and the game_mode encodings.
// The mode macros are the game-wide encodings; they are guarded so another header may supply them first.

`ifndef SCATTER_MODE
`define SCATTER_MODE 2'd0
`endif
`ifndef CHASE_MODE
`define CHASE_MODE 2'd1
`endif
`ifndef FRIGHTENED_MODE
`define FRIGHTENED_MODE 2'd2
`endif

package ghost_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCATTER = 2'd1,
    CHASE   = 2'd2,
    FRIGHT  = 2'd3
  } ghost_state_t;

  localparam int NUM_PHASES = 8;

  // Phase lengths in seconds; even phases scatter, odd phases chase, 0 never expires.
  localparam int PHASE_SEC [0:NUM_PHASES-1] = '{7, 20, 7, 20, 5, 20, 5, 0};

  // Longest finite phase, used to size the shared counter width.
  localparam int PHASE_SEC_MAX = 20;

  localparam logic [1:0] MODE_SCATTER    = `SCATTER_MODE;
  localparam logic [1:0] MODE_CHASE      = `CHASE_MODE;
  localparam logic [1:0] MODE_FRIGHTENED = `FRIGHTENED_MODE;

  // Bus encoding seen by the ghost target generators for each FSM state.
  function automatic logic [1:0] mode_of(input ghost_state_t s);
    case (s)
      CHASE:   return MODE_CHASE;
      FRIGHT:  return MODE_FRIGHTENED;
      default: return MODE_SCATTER;
    endcase
  endfunction

  // Schedule state owned by a phase index: odd phases chase.
  function automatic ghost_state_t sched_state(input logic [2:0] idx);
    return idx[0] ? CHASE : SCATTER;
  endfunction

endpackage

// File: rtl/ghost_mode_ctrl_tick.sv
// tick_timer: counts enabled ticks, wraps to 0 on reaching a programmable terminal value.
// tc is combinational (same cycle as the terminal enable); count updates on the next clk edge.
// In infinite mode tc never fires and the count saturates at all-ones instead of wrapping.

module tick_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             en,
  input  logic             clr,
  input  logic             infinite,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = en && !infinite && (count == term);

  // Counter: clear has priority, wrap on terminal count, saturate otherwise.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (tc) begin
        count <= '0;
      end else if (count != {WIDTH{1'b1}}) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ghost_mode_ctrl.sv
// ghost_mode_ctrl: global scatter/chase/frightened sequencer driving the shared game_mode bus.
// Outputs are registered: they change one clk edge after the causing tick or pulse; reverse is a 1-cycle pulse.
// Optional GHOST_MODE_FLASH_EN adds the end-of-fright sprite flash; otherwise fright_flash is tied low.

module ghost_mode_ctrl
  import ghost_pkg::*;
#(
  parameter int TICKS_PER_SEC = 60,
  parameter int FRIGHT_SEC    = 6,
  parameter int FLASH_SEC     = 2,
  parameter int FLASH_PERIOD  = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       tick,
  input  logic       level_start,
  input  logic       run,
  input  logic       pellet_eaten,
  input  logic       dev_mode,
  output logic [1:0] game_mode,
  output logic       reverse,
  output logic       fright_flash,
  output logic [2:0] phase_idx
);

  localparam int FR_T     = FRIGHT_SEC * TICKS_PER_SEC;
  localparam int PH_T_MAX = PHASE_SEC_MAX * TICKS_PER_SEC;
  localparam int CNT_MAX  = (PH_T_MAX > FR_T) ? PH_T_MAX : FR_T;
  localparam int CNT_W    = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] FR_TERM = CNT_W'(FR_T - 1);

  ghost_state_t     state_q, state_nxt;
  ghost_state_t     saved_q, saved_nxt;
  ghost_state_t     sched;
  logic [2:0]       phase_nxt;
  logic             rev_nxt;
  logic             tick_en, ph_en, fr_en;
  logic             ph_clr, fr_clr;
  logic             ph_tc, fr_tc;
  logic             ph_inf;
  logic [31:0]      ph_ticks;
  logic [CNT_W-1:0] ph_term;
  logic [CNT_W-1:0] ph_cnt, fr_cnt;

  // dev_mode and run both stop time; only the schedule owner of the current state counts.
  assign tick_en = tick && run && !dev_mode;
  assign ph_en   = tick_en && ((state_q == SCATTER) || (state_q == CHASE));
  assign fr_en   = tick_en && (state_q == FRIGHT);

  assign ph_ticks = 32'(PHASE_SEC[phase_idx]) * 32'(TICKS_PER_SEC);
  assign ph_inf   = (ph_ticks == 32'd0);
  assign ph_term  = CNT_W'(ph_ticks - 32'd1);

  tick_timer #(.WIDTH(CNT_W)) u_phase_timer (
    .clk      (clk),
    .resetN   (resetN),
    .en       (ph_en),
    .clr      (ph_clr),
    .infinite (ph_inf),
    .term     (ph_term),
    .count    (ph_cnt),
    .tc       (ph_tc)
  );

  tick_timer #(.WIDTH(CNT_W)) u_fright_timer (
    .clk      (clk),
    .resetN   (resetN),
    .en       (fr_en),
    .clr      (fr_clr),
    .infinite (1'b0),
    .term     (FR_TERM),
    .count    (fr_cnt),
    .tc       (fr_tc)
  );

  // Next state: level_start beats phase expiry, which beats pellet; expiry+pellet still reverses once.
  always_comb begin
    state_nxt = state_q;
    saved_nxt = saved_q;
    phase_nxt = phase_idx;
    sched     = state_q;
    rev_nxt   = 1'b0;
    ph_clr    = 1'b0;
    fr_clr    = 1'b0;
    if (level_start) begin
      state_nxt = SCATTER;
      saved_nxt = SCATTER;
      phase_nxt = 3'd0;
      ph_clr    = 1'b1;
      fr_clr    = 1'b1;
    end else begin
      case (state_q)
        SCATTER, CHASE: begin
          if (ph_tc) begin
            phase_nxt = phase_idx + 3'd1;
            sched     = sched_state(phase_nxt);
            state_nxt = sched;
            rev_nxt   = 1'b1;
          end
          if (pellet_eaten) begin
            saved_nxt = sched;
            state_nxt = FRIGHT;
            fr_clr    = 1'b1;
            rev_nxt   = 1'b1;
          end
        end
        FRIGHT: begin
          if (pellet_eaten) begin
            fr_clr = 1'b1;
          end else if (fr_tc) begin
            state_nxt = saved_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and registered outputs; dev_mode masks the bus to scatter and suppresses reverse.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      saved_q   <= SCATTER;
      phase_idx <= 3'd0;
      game_mode <= MODE_SCATTER;
      reverse   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      saved_q   <= saved_nxt;
      phase_idx <= phase_nxt;
      game_mode <= dev_mode ? MODE_SCATTER : mode_of(state_nxt);
      reverse   <= rev_nxt && !dev_mode;
    end
  end

`ifdef GHOST_MODE_FLASH_EN
  localparam int FLASH_T = FLASH_SEC * TICKS_PER_SEC;
  localparam int FP_W    = (FLASH_PERIOD > 2) ? $clog2(FLASH_PERIOD) : 1;
  localparam logic [FP_W-1:0] FP_LAST = FP_W'(FLASH_PERIOD - 1);

  logic [CNT_W-1:0] fr_cnt_nxt;
  logic             in_win_nxt;
  logic             win_q;
  logic [FP_W-1:0]  fp_cnt;
  logic             flash_q;

  // Window test on the post-edge fright count so the flash lines up with the mode change.
  always_comb begin
    fr_cnt_nxt = fr_cnt;
    if (fr_clr || fr_tc) begin
      fr_cnt_nxt = '0;
    end else if (fr_en) begin
      fr_cnt_nxt = fr_cnt + 1'b1;
    end
    in_win_nxt = (state_nxt == FRIGHT) &&
                 ((32'(fr_cnt_nxt) + 32'(FLASH_T)) >= 32'(FR_T));
  end

  // Flash starts at 1 on window entry and toggles every FLASH_PERIOD fright ticks.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      win_q   <= 1'b0;
      fp_cnt  <= '0;
      flash_q <= 1'b0;
    end else if (!in_win_nxt) begin
      win_q   <= 1'b0;
      fp_cnt  <= '0;
      flash_q <= 1'b0;
    end else if (!win_q) begin
      win_q   <= 1'b1;
      fp_cnt  <= '0;
      flash_q <= 1'b1;
    end else if (fr_en && !fr_clr) begin
      if (fp_cnt == FP_LAST) begin
        fp_cnt  <= '0;
        flash_q <= ~flash_q;
      end else begin
        fp_cnt <= fp_cnt + 1'b1;
      end
    end
  end

  assign fright_flash = flash_q;
`else
  assign fright_flash = 1'b0;
`endif

  // Invariants: counters never run past their terminal values; flash timing fits inside fright.
  always @(posedge clk) begin
    if (resetN) begin
      assert (ph_inf || (ph_cnt <= ph_term));
      assert (fr_cnt <= FR_TERM);
      assert ((FLASH_PERIOD >= 1) && (FLASH_SEC <= FRIGHT_SEC));
    end
  end

endmodule
